// File: rtl/cascade_sequencer.sv
// cascade_sequencer
//   Clocked successor of the 8259A cascade block. Runs the full INTA pulse
//   sequence (2 pulses in 8086 mode, 3 in 8080 mode) as either the MASTER,
//   which drives the serviced slave's ID onto CAS, or a SLAVE, which compares
//   CAS with its own ID and gates its vector-bus enable. A watchdog aborts a
//   sequence stalled between INTA edges.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   sp            role: 1=MASTER, 0=SLAVE (latched at the first INTA fall)
//   cpu_mode      0=8086 (2 pulses), 1=8080 (3 pulses) (latched likewise)
//   int_pending   MASTER has a resolved request whose IR is on slave_id
//   slave_id      MASTER: IR being serviced; SLAVE: own ID
//   slave_mask    MASTER: bit i=1 means a slave sits on IR i
//   inta_n        CPU interrupt acknowledge, active low, asynchronous
//   cas_in        CAS pin input
//   cas_out/cas_oe  CAS value and output enable (MASTER only)
//   id_match      SLAVE: CAS==own ID, sampled at the second INTA fall
//   vec_en        this device drives the data bus for the current pulse
//   seq_done      one-clock pulse on normal completion
//   err           one-clock pulse on watchdog abort
module cascade_sequencer #(
  parameter int CAS_W   = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sp,
  input  logic                  cpu_mode,
  input  logic                  int_pending,
  input  logic [CAS_W-1:0]      slave_id,
  input  logic [2**CAS_W-1:0]   slave_mask,
  input  logic                  inta_n,
  input  logic [CAS_W-1:0]      cas_in,
  output logic [CAS_W-1:0]      cas_out,
  output logic                  cas_oe,
  output logic                  id_match,
  output logic                  vec_en,
  output logic                  seq_done,
  output logic                  err
);

  localparam int WD_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int WD_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [WD_W-1:0] WD_LAST = WD_LAST_I[WD_W-1:0];

  typedef enum logic [2:0] {IDLE, P1, GAP1, P2, GAP2, P3} state_t;

  logic sync1_p0, sync2_p1, edge_p2, fall_p3, rise_p3;

  state_t           state_q, state_d;
  logic             mode_q, mode_d, role_q, role_d, casc_q, casc_d;
  logic [CAS_W-1:0] id_q, id_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [CAS_W-1:0] cas_out_q, cas_out_d;
  logic             cas_oe_q, cas_oe_d, id_match_q, id_match_d;
  logic             vec_en_q, vec_en_d, seq_done_q, seq_done_d, err_q, err_d;
  logic             any_edge, timeout, clear_all, casc_now, match;

  // Stage p0..p2: two-flop synchronizer and edge flop (idle level is 1).
  // Stage p3: registered edge strobes, so the FSM acts 4 clocks after inta_n moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_p0 <= 1'b1;
      sync2_p1 <= 1'b1;
      edge_p2  <= 1'b1;
      fall_p3  <= 1'b0;
      rise_p3  <= 1'b0;
    end else begin
      sync1_p0 <= inta_n;
      sync2_p1 <= sync1_p0;
      edge_p2  <= sync2_p1;
      fall_p3  <= edge_p2 & ~sync2_p1;
      rise_p3  <= ~edge_p2 & sync2_p1;
    end
  end

  // Stage p4: sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      role_q     <= 1'b0;
      casc_q     <= 1'b0;
      id_q       <= '0;
      wd_q       <= '0;
      cas_out_q  <= '0;
      cas_oe_q   <= 1'b0;
      id_match_q <= 1'b0;
      vec_en_q   <= 1'b0;
      seq_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      role_q     <= role_d;
      casc_q     <= casc_d;
      id_q       <= id_d;
      wd_q       <= wd_d;
      cas_out_q  <= cas_out_d;
      cas_oe_q   <= cas_oe_d;
      id_match_q <= id_match_d;
      vec_en_q   <= vec_en_d;
      seq_done_q <= seq_done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    role_d     = role_q;
    casc_d     = casc_q;
    id_d       = id_q;
    wd_d       = wd_q;
    cas_out_d  = cas_out_q;
    cas_oe_d   = cas_oe_q;
    id_match_d = id_match_q;
    vec_en_d   = vec_en_q;
    seq_done_d = 1'b0;
    err_d      = 1'b0;
    clear_all  = 1'b0;
    casc_now   = sp & slave_mask[slave_id];
    match      = ~role_q & (cas_in == id_q);
    any_edge   = fall_p3 | rise_p3;

    // Any processed edge restarts the watchdog, so a rise landing on the
    // timeout clock wins and the sequence progresses normally.
    if (any_edge)
      wd_d = '0;
    else if (state_q != IDLE)
      wd_d = wd_q + 1'b1;
    timeout = (TIMEOUT != 0) && !any_edge && (state_q != IDLE) && (wd_q == WD_LAST);

    case (state_q)
      IDLE: begin
        if (fall_p3 && (int_pending || !sp)) begin
          state_d   = P1;
          mode_d    = cpu_mode;
          role_d    = sp;
          casc_d    = casc_now;
          id_d      = slave_id;
          cas_out_d = casc_now ? slave_id : '0;
          cas_oe_d  = casc_now;
        end
      end
      P1: if (rise_p3) state_d = GAP1;
      GAP1: begin
        if (fall_p3) begin
          state_d    = P2;
          id_match_d = match;
          vec_en_d   = role_q ? ~casc_q : match;
        end
      end
      P2: begin
        if (rise_p3) begin
          vec_en_d = 1'b0;
          if (!mode_q) begin
            state_d    = IDLE;
            seq_done_d = 1'b1;
            clear_all  = 1'b1;
          end else begin
            state_d = GAP2;
          end
        end
      end
      GAP2: begin
        if (fall_p3) begin
          state_d  = P3;
          vec_en_d = role_q ? ~casc_q : id_match_q;
        end
      end
      P3: begin
        if (rise_p3) begin
          state_d    = IDLE;
          seq_done_d = 1'b1;
          clear_all  = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        clear_all = 1'b1;
      end
    endcase

    if (timeout) begin
      state_d   = IDLE;
      err_d     = 1'b1;
      clear_all = 1'b1;
    end

    if (clear_all) begin
      cas_out_d  = '0;
      cas_oe_d   = 1'b0;
      vec_en_d   = 1'b0;
      id_match_d = 1'b0;
    end
  end

  // A SLAVE never drives CAS, whatever the sequencer state.
  assign cas_oe   = cas_oe_q & sp;
  assign cas_out  = cas_out_q;
  assign id_match = id_match_q;
  assign vec_en   = vec_en_q;
  assign seq_done = seq_done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_cascade_sequencer.sv
module tb_cascade_sequencer;

  localparam int CAS_W   = 3;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst_n, sp, cpu_mode, int_pending, inta_n;
  logic [CAS_W-1:0] slave_id, cas_in;
  logic [7:0]       slave_mask;
  logic [CAS_W-1:0] cas_out;
  logic             cas_oe, id_match, vec_en, seq_done, err;

  cascade_sequencer #(.CAS_W(CAS_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .sp(sp), .cpu_mode(cpu_mode),
    .int_pending(int_pending), .slave_id(slave_id), .slave_mask(slave_mask),
    .inta_n(inta_n), .cas_in(cas_in), .cas_out(cas_out), .cas_oe(cas_oe),
    .id_match(id_match), .vec_en(vec_en), .seq_done(seq_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CAS_W-1:0] cas_out;
    logic             cas_oe;
    logic             id_match;
    logic             vec_en;
    logic             seq_done;
    logic             err;
  } obs_t;

  obs_t sb_q[$];
  obs_t cur;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   exp_done = 0;
  int   exp_err = 0;

  always @(negedge clk) begin
    if (seq_done === 1'b1) done_cnt <= done_cnt + 1;
    if (err === 1'b1) err_cnt <= err_cnt + 1;
  end

  function automatic obs_t mk(input logic [CAS_W-1:0] co, input logic oe, input logic im,
                              input logic ve, input logic sd, input logic er);
    obs_t o;
    o.cas_out = co; o.cas_oe = oe; o.id_match = im; o.vec_en = ve; o.seq_done = sd; o.err = er;
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(cas_out, cas_oe, id_match, vec_en, seq_done, err);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one inta_n level; outputs must hold for 3 clocks and show the
  // queued expectation after the 4th.
  task automatic inta(input logic lvl, input obs_t exp, input string tag, input int tail);
    obs_t h;
    @(negedge clk);
    inta_n = lvl;
    sb_q.push_back(exp);
    repeat (3) @(posedge clk);
    #1;
    h = cur; h.seq_done = 1'b0; h.err = 1'b0;
    chk({tag, "_hold"}, 32'(sample()), 32'(h));
    @(posedge clk);
    #1;
    h = sb_q.pop_front();
    chk(tag, 32'(sample()), 32'(h));
    cur = h;
    repeat (tail) @(posedge clk);
  endtask

  task automatic setup(input logic s, input logic m, input logic pend,
                       input logic [CAS_W-1:0] id, input logic [7:0] mask, input logic [CAS_W-1:0] ci);
    @(negedge clk);
    sp = s; cpu_mode = m; int_pending = pend; slave_id = id; slave_mask = mask; cas_in = ci;
  endtask

  initial begin
    obs_t z, e;
    z = mk('0, 0, 0, 0, 0, 0);
    cur = z;
    rst_n = 1'b0; inta_n = 1'b1; sp = 1'b0; cpu_mode = 1'b0; int_pending = 1'b0;
    slave_id = '0; slave_mask = '0; cas_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", 32'(sample()), 32'(z));
    @(negedge clk);
    rst_n = 1'b1;

    // MASTER 8086, cascaded slave on IR2
    setup(1, 0, 1, 3'd2, 8'h04, 3'd0);
    inta(0, mk(3'd2, 1, 0, 0, 0, 0), "m_casc_f1", 4);
    inta(1, mk(3'd2, 1, 0, 0, 0, 0), "m_casc_r1", 4);
    inta(0, mk(3'd2, 1, 0, 0, 0, 0), "m_casc_f2", 4);
    inta(1, mk(3'd0, 0, 0, 0, 1, 0), "m_casc_r2", 4);
    exp_done++;
    chk("m_casc_done_cnt", done_cnt, exp_done);

    // MASTER 8086, no slave on IR5: master supplies the vector in pulse 2
    setup(1, 0, 1, 3'd5, 8'h00, 3'd0);
    inta(0, z, "m_own_f1", 4);
    inta(1, z, "m_own_r1", 4);
    inta(0, mk(3'd0, 0, 0, 1, 0, 0), "m_own_f2", 4);
    inta(1, mk(3'd0, 0, 0, 0, 1, 0), "m_own_r2", 4);
    exp_done++;
    chk("m_own_done_cnt", done_cnt, exp_done);

    // MASTER with no pending request: pulse ignored
    setup(1, 0, 0, 3'd2, 8'h04, 3'd0);
    inta(0, z, "m_idle_f", 4);
    inta(1, z, "m_idle_r", 4);
    chk("m_idle_done_cnt", done_cnt, exp_done);

    // SLAVE ID 3, 8080 mode, CAS matches
    setup(0, 1, 0, 3'd3, 8'hff, 3'd3);
    inta(0, z, "s_hit_f1", 4);
    inta(1, z, "s_hit_r1", 4);
    inta(0, mk(3'd0, 0, 1, 1, 0, 0), "s_hit_f2", 4);
    inta(1, mk(3'd0, 0, 1, 0, 0, 0), "s_hit_r2", 4);
    inta(0, mk(3'd0, 0, 1, 1, 0, 0), "s_hit_f3", 4);
    inta(1, mk(3'd0, 0, 0, 0, 1, 0), "s_hit_r3", 4);
    exp_done++;
    chk("s_hit_done_cnt", done_cnt, exp_done);

    // SLAVE ID 3, 8080 mode, CAS=6 mismatches
    setup(0, 1, 0, 3'd3, 8'hff, 3'd6);
    inta(0, z, "s_miss_f1", 4);
    inta(1, z, "s_miss_r1", 4);
    inta(0, z, "s_miss_f2", 4);
    inta(1, z, "s_miss_r2", 4);
    inta(0, z, "s_miss_f3", 4);
    inta(1, mk(3'd0, 0, 0, 0, 1, 0), "s_miss_r3", 4);
    exp_done++;
    chk("s_miss_done_cnt", done_cnt, exp_done);

    // Watchdog: one pulse then inta_n stays high
    setup(1, 0, 1, 3'd2, 8'h04, 3'd0);
    inta(0, mk(3'd2, 1, 0, 0, 0, 0), "to_f1", 4);
    inta(1, mk(3'd2, 1, 0, 0, 0, 0), "to_r1", 0);
    sb_q.push_back(mk(3'd0, 0, 0, 0, 0, 1));
    repeat (15) @(posedge clk);
    #1;
    chk("to_before", 32'(sample()), 32'(mk(3'd2, 1, 0, 0, 0, 0)));
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("to_err", 32'(sample()), 32'(e));
    cur = e;
    repeat (3) @(posedge clk);
    exp_err++;
    chk("to_err_cnt", err_cnt, exp_err);
    chk("to_done_cnt", done_cnt, exp_done);
    setup(1, 0, 1, 3'd5, 8'h00, 3'd0);
    inta(0, z, "to_next_f1", 4);
    inta(1, z, "to_next_r1", 4);
    inta(0, mk(3'd0, 0, 0, 1, 0, 0), "to_next_f2", 4);
    inta(1, mk(3'd0, 0, 0, 0, 1, 0), "to_next_r2", 4);
    exp_done++;
    chk("to_next_done_cnt", done_cnt, exp_done);

    // Async reset during P2 of a cascaded MASTER sequence
    setup(1, 0, 1, 3'd2, 8'h04, 3'd0);
    inta(0, mk(3'd2, 1, 0, 0, 0, 0), "rst_f1", 4);
    inta(1, mk(3'd2, 1, 0, 0, 0, 0), "rst_r1", 4);
    inta(0, mk(3'd2, 1, 0, 0, 0, 0), "rst_f2", 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", 32'(sample()), 32'(z));
    cur = z;
    @(negedge clk);
    inta_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    setup(1, 0, 1, 3'd7, 8'h80, 3'd0);
    inta(0, mk(3'd7, 1, 0, 0, 0, 0), "rst_next_f1", 4);
    inta(1, mk(3'd7, 1, 0, 0, 0, 0), "rst_next_r1", 4);
    inta(0, mk(3'd7, 1, 0, 0, 0, 0), "rst_next_f2", 4);
    inta(1, mk(3'd0, 0, 0, 0, 1, 0), "rst_next_r2", 4);
    exp_done++;
    chk("rst_next_done_cnt", done_cnt, exp_done);
    chk("final_err_cnt", err_cnt, exp_err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
